fir_seq_filter: RTL and testbench

- Parametrised symmetric FIR low-pass for the heart-rate signal chain.
- Sits between the SPI sample capture and the peak detector.
- Adds a valid/ready handshake, a time-multiplexed single multiplier, run-time coefficient writes, round-half-up with unsigned saturation, and a bypass mode.
- Default configuration is 31 taps, 10-bit samples, and 16 unique coefficients scaled by 2^10.

---
 rtl/fir_seq_filter.sv | 146 ++++++++++++++
 tb/tb_fir_seq_filter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_seq_filter.sv
// Symmetric FIR low-pass with one time-multiplexed multiplier, valid/ready input,
// run-time coefficient writes, round-half-up with unsigned saturation, and bypass.
module fir_seq_filter #(
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned TAPS      = 31,
  parameter int unsigned COEF_W    = 8,
  parameter int unsigned FRAC_BITS = 10,
  parameter logic [((TAPS+1)/2)*COEF_W-1:0] COEF_INIT = {
    8'd68, 8'd67, 8'd65, 8'd61, 8'd56, 8'd50, 8'd43, 8'd36,
    8'd29, 8'd23, 8'd17, 8'd12, 8'd8,  8'd6,  8'd4,  8'd3
  }
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 sample_valid,
  output logic                                 sample_ready,
  input  logic [DATA_W-1:0]                    sample_in,
  input  logic                                 bypass,
  input  logic                                 coef_we,
  input  logic [$clog2((TAPS+1)/2)-1:0]        coef_addr,
  input  logic [COEF_W-1:0]                    coef_data,
  output logic                                 coef_wr_err,
  output logic                                 out_valid,
  output logic [DATA_W-1:0]                    out_data,
  output logic                                 out_sat,
  output logic                                 busy
);

  localparam int unsigned H      = (TAPS + 1) / 2;
  localparam int unsigned ADDR_W = $clog2(H);
  localparam int unsigned TAP_W  = $clog2(TAPS);
  localparam int unsigned PRE_W  = DATA_W + 1;
  localparam int unsigned PROD_W = PRE_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + $clog2(H);
  localparam logic [ACC_W:0] RND = {{ACC_W{1'b0}}, 1'b1} << (FRAC_BITS - 1);

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e              r_state, w_state_d;
  logic [DATA_W-1:0]   r_v    [TAPS];
  logic [COEF_W-1:0]   r_coef [H];
  logic [ACC_W-1:0]    r_acc;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_byp;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_sat;
  logic                r_wr_err;

  logic [TAP_W-1:0]    w_lo_idx, w_hi_idx;
  logic                w_centre;
  logic [PRE_W-1:0]    w_pre;
  logic [PROD_W-1:0]   w_prod;
  logic [ACC_W:0]      w_rounded;
  logic [ACC_W:0]      w_res;
  logic                w_sat;
  logic                w_addr_ok;

  // With a power-of-two H every address is in range.
  if (H == (1 << ADDR_W)) begin : g_addr_full
    assign w_addr_ok = 1'b1;
  end else begin : g_addr_part
    assign w_addr_ok = (coef_addr < ADDR_W'(H));
  end

  assign sample_ready = (r_state == StIdle);
  assign busy         = (r_state != StIdle);
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_sat      = r_out_sat;
  assign coef_wr_err  = r_wr_err;

  assign w_lo_idx  = TAP_W'(r_idx);
  assign w_hi_idx  = TAP_W'(TAPS - 1) - w_lo_idx;
  assign w_centre  = (r_idx == ADDR_W'(H - 1));
  assign w_pre     = w_centre ? {1'b0, r_v[w_lo_idx]}
                              : {1'b0, r_v[w_lo_idx]} + {1'b0, r_v[w_hi_idx]};
  assign w_prod    = PROD_W'(w_pre) * PROD_W'(r_coef[r_idx]);
  assign w_rounded = {1'b0, r_acc} + RND;
  assign w_res     = w_rounded >> FRAC_BITS;
  assign w_sat     = |w_res[ACC_W:DATA_W];

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (sample_valid) w_state_d = StMac;
      StMac:   if (w_centre)     w_state_d = StOut;
      StOut:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) r_v[k] <= '0;
      for (int k = 0; k < H; k++)    r_coef[k] <= COEF_INIT[k*COEF_W +: COEF_W];
      r_acc       <= '0;
      r_idx       <= '0;
      r_byp       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_wr_err    <= 1'b0;
      // Writes only happen in IDLE, so the MAC never sees a coefficient change mid-sum.
      if (coef_we) begin
        if ((r_state == StIdle) && w_addr_ok) r_coef[coef_addr] <= coef_data;
        else                                  r_wr_err <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (sample_valid) begin
            for (int k = 0; k < TAPS - 1; k++) r_v[k] <= r_v[k+1];
            r_v[TAPS-1] <= sample_in;
            r_acc       <= '0;
            r_idx       <= '0;
            r_byp       <= bypass;
          end
        end
        StMac: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          if (!w_centre) r_idx <= r_idx + 1'b1;
        end
        StOut: begin
          r_out_valid <= 1'b1;
          if (r_byp) begin
            r_out_data <= r_v[TAPS-1];
            r_out_sat  <= 1'b0;
          end else begin
            r_out_data <= w_sat ? {DATA_W{1'b1}} : w_res[DATA_W-1:0];
            r_out_sat  <= w_sat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_filter.sv
// Directed bench for fir_seq_filter: impulse/DC/saturation tables plus handshake,
// coefficient-write, mid-computation reset and bypass sequences.
module tb_fir_seq_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_valid;
  logic       sample_ready;
  logic [9:0] sample_in;
  logic       bypass;
  logic       coef_we;
  logic [3:0] coef_addr;
  logic [7:0] coef_data;
  logic       coef_wr_err;
  logic       out_valid;
  logic [9:0] out_data;
  logic       out_sat;
  logic       busy;

  // Small instance (H = 3) so an out-of-range address is representable.
  logic       s_we;
  logic [1:0] s_addr;
  logic [7:0] s_data;
  logic       s_ready, s_err, s_ov, s_os, s_busy;
  logic [9:0] s_od;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int acc_edge;

  typedef struct {
    logic [9:0] din;
    logic [9:0] exp_d;
    logic       exp_s;
  } vec_t;

  vec_t tbl [32];
  int   imp_exp [16];

  fir_seq_filter dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_in(sample_in), .bypass(bypass), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_wr_err(coef_wr_err), .out_valid(out_valid),
    .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  fir_seq_filter #(.TAPS(5), .COEF_INIT(24'h80_00_00)) dut_small (
    .clk(clk), .reset(reset), .sample_valid(1'b0), .sample_ready(s_ready),
    .sample_in(10'd0), .bypass(1'b0), .coef_we(s_we), .coef_addr(s_addr),
    .coef_data(s_data), .coef_wr_err(s_err), .out_valid(s_ov),
    .out_data(s_od), .out_sat(s_os), .busy(s_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sample_valid = 1'b0; sample_in = '0; bypass = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    s_we = 1'b0; s_addr = '0; s_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns #1 after the accepting edge.
  task automatic accept(input logic [9:0] d, input logic byp);
    int t = 0;
    sample_in = d; bypass = byp; sample_valid = 1'b1;
    while (!sample_ready && t < 40) begin @(negedge clk); t++; end
    if (!sample_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    acc_edge = cyc;
    sample_valid = 1'b0;
  endtask

  // Waits for out_valid; lat = edges from accept to the edge raising out_valid.
  task automatic wait_out(output logic [9:0] od, output logic os, output int lat);
    int n = 0;
    lat = -1;
    while (n < 60) begin
      @(posedge clk); #1; n++;
      if (out_valid) begin lat = cyc - acc_edge; break; end
    end
    od = out_data; os = out_sat;
    @(negedge clk);
  endtask

  task automatic xfer(input logic [9:0] d, input logic byp,
                      output logic [9:0] od, output logic os, output int lat);
    accept(d, byp);
    wait_out(od, os, lat);
  endtask

  // Called at a negedge; returns coef_wr_err just after the write edge, at the next negedge.
  task automatic coef_write(input logic [3:0] a, input logic [7:0] d, output logic err);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
    err = coef_wr_err;
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] od;
    logic       os, e;
    int         lat, bad, seen;
    int         acc_q[$];
    int         out_q[$];

    imp_exp = '{3, 4, 6, 8, 12, 17, 22, 28, 35, 42, 49, 55, 60, 63, 65, 66};
    for (int k = 0; k < 31; k++)
      tbl[k] = '{(k == 0) ? 10'd1000 : 10'd0, 10'(imp_exp[(k <= 15) ? k : 30 - k]), 1'b0};
    tbl[31] = '{10'd0, 10'd0, 1'b0};

    do_reset();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_wr_err", int'(coef_wr_err), 0);
    check("rst_busy", int'(busy), 0);

    // Impulse response
    for (int k = 0; k < 32; k++) begin
      xfer(tbl[k].din, 1'b0, od, os, lat);
      check($sformatf("imp_data[%0d]", k), int'(od), int'(tbl[k].exp_d));
      check($sformatf("imp_sat[%0d]", k), int'(os), int'(tbl[k].exp_s));
      check($sformatf("imp_lat[%0d]", k), lat, 17);
    end

    // DC gain: coefficients sum to 1028
    do_reset();
    for (int k = 0; k < 32; k++) begin
      xfer(10'd100, 1'b0, od, os, lat);
      if (k == 0) check("dc_first", int'(od), 0);
      if (k >= 30) begin
        check($sformatf("dc_data[%0d]", k), int'(od), 100);
        check($sformatf("dc_sat[%0d]", k), int'(os), 0);
      end
    end

    // Saturation: 1023*1028 rounds to 1027
    do_reset();
    for (int k = 0; k < 32; k++) begin
      xfer(10'd1023, 1'b0, od, os, lat);
      if (k == 0) begin
        check("sat_first_data", int'(od), 3);
        check("sat_first_sat", int'(os), 0);
      end
      if (k >= 30) begin
        check($sformatf("sat_data[%0d]", k), int'(od), 1023);
        check($sformatf("sat_flag[%0d]", k), int'(os), 1);
      end
    end

    // Continuous valid: accepts every 18 edges, output 17 edges after accept
    do_reset();
    @(negedge clk);
    sample_in = 10'd50; sample_valid = 1'b1; bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (sample_valid && sample_ready) acc_q.push_back(cyc + 1);
      if (out_valid) out_q.push_back(cyc);
      if (busy == sample_ready) bad++;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    check("hs_ready_vs_busy", bad, 0);
    check("hs_acc_count_ge3", int'(acc_q.size() >= 3), 1);
    check("hs_out_count_ge3", int'(out_q.size() >= 3), 1);
    if (acc_q.size() >= 3 && out_q.size() >= 3) begin
      check("hs_acc_gap0", acc_q[1] - acc_q[0], 18);
      check("hs_acc_gap1", acc_q[2] - acc_q[1], 18);
      check("hs_out_lat0", out_q[0] - acc_q[0], 17);
      check("hs_out_lat1", out_q[1] - acc_q[1], 17);
      check("hs_out_lat2", out_q[2] - acc_q[2], 17);
    end

    // Coefficient writes
    do_reset();
    @(negedge clk);
    coef_write(4'd15, 8'd0, e);
    check("cw_idle_err15", int'(e), 0);
    coef_write(4'd0, 8'd100, e);
    check("cw_idle_err0", int'(e), 0);
    accept(10'd1000, 1'b0);
    repeat (2) @(negedge clk);
    coef_write(4'd1, 8'd200, e);
    check("cw_busy_err_pulse", int'(e), 1);
    @(negedge clk);
    check("cw_busy_err_clear", int'(coef_wr_err), 0);
    wait_out(od, os, lat);
    check("cw_first_out", int'(od), 98);
    check("cw_first_lat", lat, 17);
    for (int k = 1; k < 16; k++) begin
      xfer(10'd0, 1'b0, od, os, lat);
      if (k == 1)  check("cw_c1_unchanged", int'(od), 4);
      if (k == 14) check("cw_c14", int'(od), 65);
      if (k == 15) check("cw_c15_zero", int'(od), 0);
    end

    // Out-of-range address on the H=3 instance
    s_we = 1'b1; s_addr = 2'd3; s_data = 8'd9;
    @(posedge clk); #1;
    s_we = 1'b0;
    check("small_addr3_err", int'(s_err), 1);
    @(negedge clk);
    s_we = 1'b1; s_addr = 2'd2; s_data = 8'd9;
    @(posedge clk); #1;
    s_we = 1'b0;
    check("small_addr2_err", int'(s_err), 0);
    @(negedge clk);

    // Reset five clocks after an accept aborts the computation
    accept(10'd1000, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_valid", seen, 0);
    xfer(10'd1000, 1'b0, od, os, lat);
    check("mid_rst_coef_restored", int'(od), 3);

    // Bypass
    xfer(10'd555, 1'b1, od, os, lat);
    check("byp_data", int'(od), 555);
    check("byp_sat", int'(os), 0);
    check("byp_lat", lat, 17);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
